// File: rtl/skid_pipe_reg.sv
// Generic valid/ready pipeline stage with a 2-entry (main + skid) buffer and a registered in_ready_o.
// Optional saturating stall/drop counters are enabled by defining SKID_PIPE_PERF_EN.
module skid_pipe_reg #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
`ifdef SKID_PIPE_PERF_EN
  ,
  parameter int                CNT_W   = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
`ifdef SKID_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt_o,
  output logic [CNT_W-1:0]  perf_drop_cnt_o
`endif
);

  // Encoding is {main_v, skid_v}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rdy_q, rdy_d;
  logic              in_fire, out_fire;

  assign in_fire     = in_valid_i & rdy_q;
  assign out_fire    = state_q[1] & out_ready_i;
  assign in_ready_o  = rdy_q;
  assign out_valid_o = state_q[1];
  assign out_data_o  = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = FULL;
            main_d  = in_data_i;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            state_d = SKID;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = NOP_VAL;
          end
        end
        SKID: begin
          if (out_fire) begin
            state_d = FULL;
            main_d  = skid_q;
            skid_d  = NOP_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
    // Ready is precomputed for next cycle so the stall path toward upstream is a flop.
    rdy_d = ~state_d[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef SKID_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [1:0]       stall_inc, drop_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W - 1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    stall_inc   = {1'b0, state_q[1] & ~out_ready_i & ~flush_i};
    drop_inc    = flush_i ? ({1'b0, state_q[1]} + {1'b0, state_q[0]} + {1'b0, in_fire}) : 2'd0;
    stall_cnt_d = sat_add(stall_cnt_q, stall_inc);
    drop_cnt_d  = sat_add(drop_cnt_q, drop_inc);
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Self-checking bench for skid_pipe_reg: directed scenarios plus a random run against a queue model.
// Counter checks are compiled in when SKID_PIPE_PERF_EN is defined.
module tb_skid_pipe_reg;

  localparam int DATA_W = 64;
  localparam logic [DATA_W-1:0] NOP = '0;

  logic              clk_i = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i = '0;
  logic              flush_i = 1'b0;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_ready_i = 1'b0;
`ifdef SKID_PIPE_PERF_EN
  logic [31:0]       perf_stall_cnt_o;
  logic [31:0]       perf_drop_cnt_o;
`endif

  skid_pipe_reg dut (
    .clk_i       (clk_i),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i)
`ifdef SKID_PIPE_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_drop_cnt_o  (perf_drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model: the stage is a FIFO of depth 2 whose ready flag is "fewer than 2 held".
  logic [DATA_W-1:0] mq[$];
  longint unsigned   m_stall = 0;
  longint unsigned   m_drop = 0;

  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic r,
                       input logic f, input logic rs);
    bit i_fire, o_fire;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    rst         = rs;
    i_fire = v && (mq.size() < 2);
    o_fire = (mq.size() > 0) && r;
    @(posedge clk_i);
    #1;
    if (rs) begin
      mq.delete();
      m_stall = 0;
      m_drop  = 0;
    end else if (f) begin
      m_drop += mq.size() + (i_fire ? 1 : 0);
      mq.delete();
    end else begin
      if (mq.size() > 0 && !r) m_stall++;
      if (o_fire) void'(mq.pop_front());
      if (i_fire) mq.push_back(d);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 64'hDEAD, 1'b0, 1'b1, 1'b1);
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    checks++; if (out_data_o !== NOP) begin failures++; $display("FAIL reset_data got=%h exp=%h", out_data_o, NOP); end
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
`ifdef SKID_PIPE_PERF_EN
    checks++; if (perf_stall_cnt_o !== 32'd0 || perf_drop_cnt_o !== 32'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", perf_stall_cnt_o, perf_drop_cnt_o); end
`endif
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] exp;
    for (int k = 1; k <= 3; k++) begin
      exp = 64'(k * 'h11);
      cycle(1'b1, exp, 1'b1, 1'b0, 1'b0);
      checks++; if (out_valid_o !== 1'b1 || out_data_o !== exp) begin
        failures++; $display("FAIL stream_data k=%0d got=%b/%h exp=1/%h", k, out_valid_o, out_data_o, exp); end
      checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, in_ready_o); end
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid_o !== 1'b0 || out_data_o !== NOP) begin
      failures++; $display("FAIL stream_drain got=%b/%h exp=0/%h", out_valid_o, out_data_o, NOP); end
  endtask

  task automatic test_skid_release();
    cycle(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    checks++; if (in_ready_o !== 1'b0 || out_data_o !== 64'hA) begin
      failures++; $display("FAIL skid_enter got=%b/%h exp=0/a", in_ready_o, out_data_o); end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'hB || in_ready_o !== 1'b1) begin
      failures++; $display("FAIL skid_release1 got=%b/%h/%b exp=1/b/1", out_valid_o, out_data_o, in_ready_o); end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid_o !== 1'b0 || out_data_o !== NOP) begin
      failures++; $display("FAIL skid_release2 got=%b/%h exp=0/%h", out_valid_o, out_data_o, NOP); end
  endtask

  task automatic test_skid_hold_flush();
    longint unsigned s0, d0;
    cycle(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    s0 = m_stall;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
      checks++; if (out_data_o !== 64'hA || in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
        failures++; $display("FAIL hold k=%0d got=%b/%h/%b exp=1/a/0", k, out_valid_o, out_data_o, in_ready_o); end
    end
`ifdef SKID_PIPE_PERF_EN
    checks++; if (m_stall - s0 != 5 || perf_stall_cnt_o !== 32'(m_stall)) begin
      failures++; $display("FAIL hold_stall_cnt got=%0d exp=%0d", perf_stall_cnt_o, m_stall); end
`endif
    d0 = m_drop;
    cycle(1'b1, 64'hC, 1'b0, 1'b1, 1'b0);
    checks++; if (out_valid_o !== 1'b0 || out_data_o !== NOP || in_ready_o !== 1'b1) begin
      failures++; $display("FAIL flush got=%b/%h/%b exp=0/%h/1", out_valid_o, out_data_o, in_ready_o, NOP); end
`ifdef SKID_PIPE_PERF_EN
    checks++; if (m_drop - d0 != 2 || perf_drop_cnt_o !== 32'(m_drop)) begin
      failures++; $display("FAIL flush_drop_cnt got=%0d exp=%0d", perf_drop_cnt_o, m_drop); end
`endif
    // Nothing from before the flush may reappear.
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid_o !== 1'b0 || out_data_o !== NOP) begin
      failures++; $display("FAIL flush_after got=%b/%h exp=0/%h", out_valid_o, out_data_o, NOP); end
  endtask

  task automatic test_reset_in_skid();
    cycle(1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h6, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h7, 1'b0, 1'b1, 1'b1);
    checks++; if (out_valid_o !== 1'b0 || out_data_o !== NOP || in_ready_o !== 1'b1) begin
      failures++; $display("FAIL rst_skid got=%b/%h/%b exp=0/%h/1", out_valid_o, out_data_o, in_ready_o, NOP); end
`ifdef SKID_PIPE_PERF_EN
    checks++; if (perf_stall_cnt_o !== 32'd0 || perf_drop_cnt_o !== 32'd0) begin
      failures++; $display("FAIL rst_skid_cnt got=%0d/%0d exp=0/0", perf_stall_cnt_o, perf_drop_cnt_o); end
`endif
    // Payload taken in after reset must be the first thing out, with no leftovers.
    cycle(1'b1, 64'h8, 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'h8) begin
      failures++; $display("FAIL rst_skid_next got=%b/%h exp=1/8", out_valid_o, out_data_o); end
  endtask

  task automatic test_random();
    logic              v, r, f;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp;
    int unsigned       seq = 0;
    d = {$urandom, seq};
    for (int k = 0; k < 10000; k++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 63) == 0);
      // Upstream keeps a payload until it is accepted; a tagged sequence exposes loss or duplication.
      if (v && in_ready_o && !f) begin
        cycle(v, d, r, f, 1'b0);
        seq++;
        d = {$urandom, seq};
      end else begin
        cycle(v, d, r, f, 1'b0);
      end
      exp = (mq.size() > 0) ? mq[0] : NOP;
      checks++; if (out_valid_o !== (mq.size() > 0)) begin
        failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", k, out_valid_o, mq.size() > 0); end
      checks++; if (out_data_o !== exp) begin
        failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", k, out_data_o, exp); end
      checks++; if (in_ready_o !== (mq.size() < 2)) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", k, in_ready_o, mq.size() < 2); end
`ifdef SKID_PIPE_PERF_EN
      checks++; if (perf_stall_cnt_o !== 32'(m_stall) || perf_drop_cnt_o !== 32'(m_drop)) begin
        failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", k, perf_stall_cnt_o,
                             perf_drop_cnt_o, m_stall, m_drop); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_release();
    test_skid_hold_flush();
    test_reset_in_skid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
